rvh_pmp_csr_ctrl: RTL and testbench
===================================

Name: rvh_pmp_csr_ctrl

Overview:
CSR-side writer/reader for the PMP entry array.
- Accepts M-mode CSR accesses to pmpcfg0/pmpcfg2 and pmpaddr0..15 over a valid/ready request and response handshake.
- Fans each access out as per-entry cfg_set/addr_set pulses, and gathers the per-entry pmpcfg/pmpaddr status into read data.
- Converts between the CSR word-address format and the entries' byte-address format.
- Pulses pmp_update_o after every write so the TLBs can flush.

Parameters:
PMP_ENTRY_COUNT, 16, number of PMP entries driven (multiple of 8, max 16)
PADDR_WIDTH, 56, physical address width; must match the entries

Ports:
clk  input  1  clock
rstn  input  1  asynchronous active-low reset
csr_req_vld_i  input  1  CSR request valid
csr_req_rdy_o  output  1  CSR request ready
csr_req_we_i  input  1  1 = write (returns old value), 0 = read
csr_req_addr_i  input  12  CSR address
csr_req_wdata_i  input  64  write data
csr_resp_vld_o  output  1  response valid
csr_resp_rdy_i  input  1  response ready
csr_resp_rdata_o  output  64  old CSR value
csr_resp_illegal_o  output  1  illegal CSR access
cfg_set_vld_o  output  PMP_ENTRY_COUNT  per-entry cfg write pulse
cfg_set_payload_o  output  8*PMP_ENTRY_COUNT  per-entry cfg byte; entry i in [8i+7:8i]
addr_set_vld_o  output  PMP_ENTRY_COUNT  per-entry addr write pulse
addr_set_payload_o  output  64*PMP_ENTRY_COUNT  per-entry byte address; entry i in [64i+63:64i]
pmpcfg_i  input  8*PMP_ENTRY_COUNT  per-entry cfg status
pmpaddr_i  input  64*PMP_ENTRY_COUNT  per-entry byte-address status
pmp_update_o  output  1  one-cycle pulse after any legal write

Behaviour:
Clock and reset:
- Single clock clk; reset rstn is asynchronous, active-low.
- Reset: FSM returns to IDLE. csr_req_rdy_o=1. csr_resp_vld_o, csr_resp_illegal_o, pmp_update_o = 0. csr_resp_rdata_o = 0. All set_vld bits = 0.
- Reset during EXEC or RESP drops the access; no set pulse is issued after reset.

FSM states IDLE, EXEC, RESP:
- IDLE: csr_req_rdy_o=1. On vld&rdy, register we/addr/wdata and go to EXEC.
- EXEC (one cycle): csr_req_rdy_o=0.
  - If legal and we=1, drive the set_vld bits for this cycle only.
  - Capture rdata from pmpcfg_i/pmpaddr_i in this same cycle, i.e. the pre-write value.
  - Go to RESP.
- RESP: csr_resp_vld_o=1, with rdata and illegal held stable. pmp_update_o=1 on the first RESP cycle only, if a legal write occurred. On csr_resp_rdy_i go to IDLE.
- Latency: accept at T, set pulse at T+1, resp_vld from T+2. Throughput is one access per 3 cycles minimum. No new request is accepted in EXEC or RESP.

Decode:
- pmpcfg0 = 0x3A0 covers entries 0-7; pmpcfg2 = 0x3A2 covers entries 8-15. Byte k of wdata goes to entry base+k.
- pmpaddr0..15 = 0x3B0..0x3BF; entry index = addr[3:0].
- Illegal (illegal=1, rdata=0, no set pulses, no pmp_update_o):
  - 0x3A1 or 0x3A3 (odd pmpcfg on RV64);
  - any other address;
  - any entry index >= PMP_ENTRY_COUNT.

pmpcfg write:
- All 8 covered entries get cfg_set_vld=1.
- The entries themselves ignore the write when locked (L) or when a later entry locks them (TOR+L).
- Read: concatenate pmpcfg_i bytes of the 8 covered entries.

pmpaddr write:
- addr_set_payload = {wdata[61:0], 2'b00} & mask with bits [63:PADDR_WIDTH] cleared.
- Read: rdata = {2'b00, pmpaddr_i[63:2]} with bits [63:PADDR_WIDTH-2] forced 0.

Idle outputs:
- Payload outputs for non-selected entries = 0.
- Set_vld is 0 in all states except EXEC.

Optional Feature:
RVH_PMP_WARL_EN
- Defined: cfg bytes are sanitised before driving the payload.
  - Bits [6:5] are cleared.
  - The reserved combination R=0,W=1 is written as R=0,W=0, with X, A and L preserved.
- Undefined: cfg bytes pass through unmodified.

Test Plan:
- Reset, then idle -> rdy=1, resp_vld=0, all set_vld=0, pmp_update_o=0.
- Write 0x3B0 with wdata=0x0000_0000_2000_0000 -> EXEC: addr_set_vld[0]=1, payload0=0x8000_0000. Response rdata=old value. pmp_update_o pulse at T+2. Read-back of 0x3B0 gives 0x2000_0000.
- Write 0x3A0 with wdata=0x0000_0000_0000_1F0F -> cfg_set_vld[7:0]=0xFF. Entry0 gets cfg 0x0F, entry1 gets 0x1F (NAPOT). Read-back rdata=0x1F0F.
- With RVH_PMP_WARL_EN defined, write 0x3A0 byte0=0x62 -> payload0=0x00. Without it -> payload0=0x62.
- Access to 0x3A1, then 0x3C0 -> illegal=1, rdata=0, no set_vld, no pmp_update_o.
- Hold csr_resp_rdy_i=0 for 5 cycles while pulsing req_vld -> rdy=0, response stable, no second accept. Assert rstn low mid-RESP -> resp_vld=0 asynchronously, IDLE after release.

Source files
------------

// File: rtl/rvh_pmp_csr_ctrl.sv
// rvh_pmp_csr_ctrl
//   CSR-side writer/reader for the PMP entry array. Accepts pmpcfg0/pmpcfg2
//   and pmpaddr0..15 accesses over a valid/ready request/response pair,
//   fans writes out as one-cycle per-entry set pulses and gathers the
//   per-entry status back into the old-value read data.
//
//   Optional feature macro: RVH_PMP_WARL_EN
//     defined   - cfg bytes are sanitised (bits [6:5] cleared, reserved
//                 R=0/W=1 written as R=0/W=0) before driving the payload
//     undefined - cfg bytes pass through unmodified
module rvh_pmp_csr_ctrl #(
  parameter int PMP_ENTRY_COUNT = 16,
  parameter int PADDR_WIDTH     = 56
) (
  input  logic                         clk,
  input  logic                         rstn,
  input  logic                         csr_req_vld_i,
  output logic                         csr_req_rdy_o,
  input  logic                         csr_req_we_i,
  input  logic [11:0]                  csr_req_addr_i,
  input  logic [63:0]                  csr_req_wdata_i,
  output logic                         csr_resp_vld_o,
  input  logic                         csr_resp_rdy_i,
  output logic [63:0]                  csr_resp_rdata_o,
  output logic                         csr_resp_illegal_o,
  output logic [PMP_ENTRY_COUNT-1:0]   cfg_set_vld_o,
  output logic [8*PMP_ENTRY_COUNT-1:0] cfg_set_payload_o,
  output logic [PMP_ENTRY_COUNT-1:0]   addr_set_vld_o,
  output logic [64*PMP_ENTRY_COUNT-1:0] addr_set_payload_o,
  input  logic [8*PMP_ENTRY_COUNT-1:0] pmpcfg_i,
  input  logic [64*PMP_ENTRY_COUNT-1:0] pmpaddr_i,
  output logic                         pmp_update_o
);

  // Byte-address bits kept on a write, and word-address bits kept on a read.
  // Computed in 64-bit arithmetic so PADDR_WIDTH=64 wraps to all ones.
  localparam logic [63:0] WR_MASK = (64'd1 << PADDR_WIDTH) - 64'd1;
  localparam logic [63:0] RD_MASK = (64'd1 << (PADDR_WIDTH - 2)) - 64'd1;

  localparam logic [11:0] CSR_PMPCFG0 = 12'h3A0;
  localparam logic [11:0] CSR_PMPCFG2 = 12'h3A2;
  localparam logic [7:0]  CSR_PMPADDR_HI = 8'h3B;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t r_state;
  state_t w_nextState;

  logic        r_we;
  logic [11:0] r_addr;
  logic [63:0] r_wdata;
  logic [63:0] r_rdata;
  logic        r_illegal;
  logic        r_update;

  logic        w_accept;
  logic        w_isCfg0;
  logic        w_isCfg2;
  logic        w_isAddr;
  logic        w_legal;
  logic        w_doWrite;
  logic [63:0] w_selAddr;
  logic [63:0] w_cfgRd;
  logic [63:0] w_rdData;
  logic [63:0] w_addrPay;

  // Legalise one cfg byte before it reaches an entry
  function automatic logic [7:0] sanitizeCfg(input logic [7:0] cfg);
    logic [7:0] res;
    res = cfg;
`ifdef RVH_PMP_WARL_EN
    res[6:5] = 2'b00;
    if (!res[0] && res[1]) begin
      res[1] = 1'b0;
    end
`endif
    return res;
  endfunction

  // Decode the captured CSR address; pmpcfg2 only exists with 16 entries
  assign w_isCfg0 = (r_addr == CSR_PMPCFG0);
  assign w_isCfg2 = (r_addr == CSR_PMPCFG2) && (PMP_ENTRY_COUNT > 8);
  assign w_isAddr = (r_addr[11:4] == CSR_PMPADDR_HI) &&
                    ({28'd0, r_addr[3:0]} < 32'(PMP_ENTRY_COUNT));
  assign w_legal  = w_isCfg0 || w_isCfg2 || w_isAddr;
  assign w_doWrite = (r_state == EXEC) && r_we && w_legal;
  assign w_accept = (r_state == IDLE) && csr_req_vld_i;

  // CSR word address -> entry byte address, clipped to the physical width
  assign w_addrPay = {r_wdata[61:0], 2'b00} & WR_MASK;

  // State register
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Next state and handshake outputs; EXEC always lasts exactly one cycle
  always_comb begin
    w_nextState    = r_state;
    csr_req_rdy_o  = 1'b0;
    csr_resp_vld_o = 1'b0;
    case (r_state)
      IDLE: begin
        csr_req_rdy_o = 1'b1;
        if (csr_req_vld_i) begin
          w_nextState = EXEC;
        end
      end
      EXEC: begin
        w_nextState = RESP;
      end
      RESP: begin
        csr_resp_vld_o = 1'b1;
        if (csr_resp_rdy_i) begin
          w_nextState = IDLE;
        end
      end
      default: begin
        w_nextState = IDLE;
      end
    endcase
  end

  // Gather the selected entry status into the old-value read data
  always_comb begin
    w_selAddr = '0;
    w_cfgRd   = '0;
    for (int i = 0; i < PMP_ENTRY_COUNT; i++) begin
      if (r_addr[3:0] == 4'(i)) begin
        w_selAddr = pmpaddr_i[64*i +: 64];
      end
      if ((i < 8) ? w_isCfg0 : w_isCfg2) begin
        w_cfgRd[8*(i%8) +: 8] = pmpcfg_i[8*i +: 8];
      end
    end
    w_rdData = '0;
    if (w_isAddr) begin
      w_rdData = (w_selAddr >> 2) & RD_MASK;
    end else if (w_isCfg0 || w_isCfg2) begin
      w_rdData = w_cfgRd;
    end
  end

  // Fan a legal write out to the covered entries during EXEC only
  always_comb begin
    cfg_set_vld_o      = '0;
    cfg_set_payload_o  = '0;
    addr_set_vld_o     = '0;
    addr_set_payload_o = '0;
    if (w_doWrite) begin
      for (int i = 0; i < PMP_ENTRY_COUNT; i++) begin
        if ((i < 8) ? w_isCfg0 : w_isCfg2) begin
          cfg_set_vld_o[i]             = 1'b1;
          cfg_set_payload_o[8*i +: 8]  = sanitizeCfg(r_wdata[8*(i%8) +: 8]);
        end
        if (w_isAddr && (r_addr[3:0] == 4'(i))) begin
          addr_set_vld_o[i]             = 1'b1;
          addr_set_payload_o[64*i +: 64] = w_addrPay;
        end
      end
    end
  end

  // Request capture in IDLE, response capture at the end of EXEC; the
  // status is sampled in the same cycle the set pulse is driven, so the
  // response carries the pre-write value
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_we      <= 1'b0;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_rdata   <= '0;
      r_illegal <= 1'b0;
      r_update  <= 1'b0;
    end else begin
      r_update <= 1'b0;
      if (w_accept) begin
        r_we    <= csr_req_we_i;
        r_addr  <= csr_req_addr_i;
        r_wdata <= csr_req_wdata_i;
      end
      if (r_state == EXEC) begin
        r_rdata   <= w_rdData;
        r_illegal <= !w_legal;
        r_update  <= r_we && w_legal;
      end
    end
  end

  assign csr_resp_rdata_o   = r_rdata;
  assign csr_resp_illegal_o = r_illegal;
  assign pmp_update_o       = r_update;

endmodule

// File: tb/tb_rvh_pmp_csr_ctrl.sv
// Self-checking bench for rvh_pmp_csr_ctrl. A small PMP entry array model
// stores whatever the DUT pulses into it and feeds its status back, so
// write-then-read sequences exercise the full format conversion.
module tb_rvh_pmp_csr_ctrl;

  localparam int N = 16;

  logic           clk;
  logic           rstn;
  logic           csr_req_vld_i;
  logic           csr_req_rdy_o;
  logic           csr_req_we_i;
  logic [11:0]    csr_req_addr_i;
  logic [63:0]    csr_req_wdata_i;
  logic           csr_resp_vld_o;
  logic           csr_resp_rdy_i;
  logic [63:0]    csr_resp_rdata_o;
  logic           csr_resp_illegal_o;
  logic [N-1:0]   cfg_set_vld_o;
  logic [8*N-1:0] cfg_set_payload_o;
  logic [N-1:0]   addr_set_vld_o;
  logic [64*N-1:0] addr_set_payload_o;
  logic [8*N-1:0] pmpcfg_i;
  logic [64*N-1:0] pmpaddr_i;
  logic           pmp_update_o;

  typedef struct packed {
    logic [63:0] rdata;
    logic        illegal;
  } resp_t;

  resp_t expQ[$];
  int    checks = 0;
  int    errors = 0;

  logic [7:0]  entCfg [N];
  logic [63:0] entAddr[N];
  logic [8*N-1:0]  lastCfgPay;
  logic [64*N-1:0] lastAddrPay;
  logic [7:0]  expWarlByte;

  rvh_pmp_csr_ctrl #(
    .PMP_ENTRY_COUNT(N),
    .PADDR_WIDTH(56)
  ) dut (
    .clk               (clk),
    .rstn              (rstn),
    .csr_req_vld_i     (csr_req_vld_i),
    .csr_req_rdy_o     (csr_req_rdy_o),
    .csr_req_we_i      (csr_req_we_i),
    .csr_req_addr_i    (csr_req_addr_i),
    .csr_req_wdata_i   (csr_req_wdata_i),
    .csr_resp_vld_o    (csr_resp_vld_o),
    .csr_resp_rdy_i    (csr_resp_rdy_i),
    .csr_resp_rdata_o  (csr_resp_rdata_o),
    .csr_resp_illegal_o(csr_resp_illegal_o),
    .cfg_set_vld_o     (cfg_set_vld_o),
    .cfg_set_payload_o (cfg_set_payload_o),
    .addr_set_vld_o    (addr_set_vld_o),
    .addr_set_payload_o(addr_set_payload_o),
    .pmpcfg_i          (pmpcfg_i),
    .pmpaddr_i         (pmpaddr_i),
    .pmp_update_o      (pmp_update_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Entry array model: preloaded on reset, updated by the set pulses
  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < N; i++) begin
        entCfg[i]  <= 8'(i + 1);
        entAddr[i] <= 64'd0;
      end
      entAddr[0] <= 64'h0000_0000_0000_1000;
      entAddr[3] <= 64'hFF80_0000_0000_0010;
      entAddr[5] <= 64'h0000_0000_0000_0040;
    end else begin
      for (int i = 0; i < N; i++) begin
        if (cfg_set_vld_o[i])  entCfg[i]  <= cfg_set_payload_o[8*i +: 8];
        if (addr_set_vld_o[i]) entAddr[i] <= addr_set_payload_o[64*i +: 64];
      end
    end
  end

  always_comb begin
    for (int i = 0; i < N; i++) begin
      pmpcfg_i[8*i +: 8]   = entCfg[i];
      pmpaddr_i[64*i +: 64] = entAddr[i];
    end
  end

  // Compare one observed value against its expectation
  task automatic checkOutput(input string name, input logic [63:0] act,
                             input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%h expected 0x%h", name, act, exp);
    end
  endtask

  // Response monitor: pops the scoreboard on every response handshake
  always @(negedge clk) begin
    resp_t exp;
    if (rstn && csr_resp_vld_o && csr_resp_rdy_i) begin
      if (expQ.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpectedResp: got rdata 0x%h with empty queue",
                 csr_resp_rdata_o);
      end else begin
        exp = expQ.pop_front();
        checkOutput("respRdata", csr_resp_rdata_o, exp.rdata);
        checkOutput("respIllegal", {63'd0, csr_resp_illegal_o}, {63'd0, exp.illegal});
      end
    end
  end

  // Issue one request and wait (bounded) until it is accepted
  task automatic applyStimulus(input logic we, input logic [11:0] addr,
                               input logic [63:0] wdata, input logic [63:0] expRd,
                               input logic expIll, input logic push);
    int waited;
    resp_t r;
    @(negedge clk);
    csr_req_vld_i   = 1'b1;
    csr_req_we_i    = we;
    csr_req_addr_i  = addr;
    csr_req_wdata_i = wdata;
    if (push) begin
      r.rdata   = expRd;
      r.illegal = expIll;
      expQ.push_back(r);
    end
    waited = 0;
    while (!csr_req_rdy_o && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    if (!csr_req_rdy_o) begin
      checks++;
      errors++;
      $display("[TB] FAIL acceptTimeout: rdy=0 after %0d cycles, required 1", waited);
    end
    @(posedge clk);
    #1;
    csr_req_vld_i = 1'b0;
  endtask

  // Full access: checks the EXEC pulses, the update pulse and the return to IDLE
  task automatic doAccess(input logic we, input logic [11:0] addr,
                          input logic [63:0] wdata, input logic [63:0] expRd,
                          input logic expIll, input logic [15:0] expCfgVld,
                          input logic [15:0] expAddrVld, input logic expUpd);
    applyStimulus(we, addr, wdata, expRd, expIll, 1'b1);
    @(negedge clk);
    checkOutput("cfgSetVld", {48'd0, cfg_set_vld_o}, {48'd0, expCfgVld});
    checkOutput("addrSetVld", {48'd0, addr_set_vld_o}, {48'd0, expAddrVld});
    checkOutput("rdyInExec", {63'd0, csr_req_rdy_o}, 64'd0);
    lastCfgPay  = cfg_set_payload_o;
    lastAddrPay = addr_set_payload_o;
    @(negedge clk);
    checkOutput("pmpUpdate", {63'd0, pmp_update_o}, {63'd0, expUpd});
    checkOutput("setVldInResp", {48'd0, cfg_set_vld_o | addr_set_vld_o}, 64'd0);
    @(negedge clk);
    checkOutput("pmpUpdateOff", {63'd0, pmp_update_o}, 64'd0);
    checkOutput("rdyIdle", {63'd0, csr_req_rdy_o}, 64'd1);
  endtask

  initial begin
    int waited;
    rstn            = 1'b0;
    csr_req_vld_i   = 1'b0;
    csr_req_we_i    = 1'b0;
    csr_req_addr_i  = '0;
    csr_req_wdata_i = '0;
    csr_resp_rdy_i  = 1'b1;

    // Reset state
    #12;
    checkOutput("rstRdy", {63'd0, csr_req_rdy_o}, 64'd1);
    checkOutput("rstRespVld", {63'd0, csr_resp_vld_o}, 64'd0);
    checkOutput("rstRdata", csr_resp_rdata_o, 64'd0);
    checkOutput("rstSetVld", {48'd0, cfg_set_vld_o | addr_set_vld_o}, 64'd0);
    checkOutput("rstUpdate", {63'd0, pmp_update_o}, 64'd0);
    @(negedge clk);
    rstn = 1'b1;
    repeat (2) @(negedge clk);
    checkOutput("idleRespVld", {63'd0, csr_resp_vld_o}, 64'd0);
    checkOutput("idleIllegal", {63'd0, csr_resp_illegal_o}, 64'd0);

    // pmpaddr0 write: payload is byte address, response is old word address
    doAccess(1'b1, 12'h3B0, 64'h0000_0000_2000_0000, 64'h0000_0000_0000_0400, 1'b0,
             16'h0000, 16'h0001, 1'b1);
    checkOutput("addrPay0", lastAddrPay[63:0], 64'h0000_0000_8000_0000);
    checkOutput("addrPayOthersZero", {63'd0, |lastAddrPay[64*N-1:64]}, 64'd0);
    checkOutput("cfgPayZero", {63'd0, |lastCfgPay}, 64'd0);
    doAccess(1'b0, 12'h3B0, 64'd0, 64'h0000_0000_2000_0000, 1'b0,
             16'h0000, 16'h0000, 1'b0);

    // pmpaddr3: high bits clipped on write and on read
    doAccess(1'b1, 12'h3B3, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0020_0000_0000_0004, 1'b0,
             16'h0000, 16'h0008, 1'b1);
    checkOutput("addrPay3", lastAddrPay[64*3 +: 64], 64'h00FF_FFFF_FFFF_FFFC);
    doAccess(1'b0, 12'h3B3, 64'd0, 64'h003F_FFFF_FFFF_FFFF, 1'b0,
             16'h0000, 16'h0000, 1'b0);

    // pmpcfg0 write and read-back
    doAccess(1'b1, 12'h3A0, 64'h0000_0000_0000_1F0F, 64'h0807_0605_0403_0201, 1'b0,
             16'h00FF, 16'h0000, 1'b1);
    checkOutput("cfgPay0", {56'd0, lastCfgPay[7:0]}, 64'h0F);
    checkOutput("cfgPay1", {56'd0, lastCfgPay[15:8]}, 64'h1F);
    doAccess(1'b0, 12'h3A0, 64'd0, 64'h0000_0000_0000_1F0F, 1'b0,
             16'h0000, 16'h0000, 1'b0);

    // pmpcfg2 write covers entries 8..15
    doAccess(1'b1, 12'h3A2, 64'h8877_6655_4433_2211, 64'h100F_0E0D_0C0B_0A09, 1'b0,
             16'hFF00, 16'h0000, 1'b1);
    checkOutput("cfgPay8", {56'd0, lastCfgPay[71:64]}, 64'h11);
    checkOutput("cfgPay15", {56'd0, lastCfgPay[127:120]}, 64'h88);

    // Reserved cfg encoding: sanitised only when the WARL feature is built in
`ifdef RVH_PMP_WARL_EN
    expWarlByte = 8'h00;
`else
    expWarlByte = 8'h62;
`endif
    doAccess(1'b1, 12'h3A0, 64'h0000_0000_0000_0062, 64'h0000_0000_0000_1F0F, 1'b0,
             16'h00FF, 16'h0000, 1'b1);
    checkOutput("cfgPayWarl", {56'd0, lastCfgPay[7:0]}, {56'd0, expWarlByte});

    // Illegal addresses
    doAccess(1'b1, 12'h3A1, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1'b1, 16'h0000, 16'h0000, 1'b0);
    doAccess(1'b0, 12'h3C0, 64'd0, 64'd0, 1'b1, 16'h0000, 16'h0000, 1'b0);
    doAccess(1'b1, 12'h3A3, 64'h1234, 64'd0, 1'b1, 16'h0000, 16'h0000, 1'b0);

    // Response backpressure with a pending second request, then reset mid-RESP
    csr_resp_rdy_i = 1'b0;
    applyStimulus(1'b1, 12'h3B5, 64'h100, 64'd0, 1'b0, 1'b0);
    @(negedge clk);
    checkOutput("bpAddrSetVld", {48'd0, addr_set_vld_o}, 64'h0020);
    @(negedge clk);
    csr_req_vld_i  = 1'b1;
    csr_req_we_i   = 1'b0;
    csr_req_addr_i = 12'h3B0;
    for (int c = 0; c < 5; c++) begin
      checkOutput("bpRespVld", {63'd0, csr_resp_vld_o}, 64'd1);
      checkOutput("bpRdy", {63'd0, csr_req_rdy_o}, 64'd0);
      checkOutput("bpRdata", csr_resp_rdata_o, 64'h10);
      @(negedge clk);
    end
    #2;
    rstn = 1'b0;
    #1;
    checkOutput("asyncRespVld", {63'd0, csr_resp_vld_o}, 64'd0);
    checkOutput("asyncRdy", {63'd0, csr_req_rdy_o}, 64'd1);
    csr_req_vld_i  = 1'b0;
    csr_resp_rdy_i = 1'b1;
    @(negedge clk);
    rstn = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checkOutput("postRstRespVld", {63'd0, csr_resp_vld_o}, 64'd0);
      checkOutput("postRstSetVld", {48'd0, cfg_set_vld_o | addr_set_vld_o}, 64'd0);
      checkOutput("postRstUpdate", {63'd0, pmp_update_o}, 64'd0);
    end
    doAccess(1'b0, 12'h3B5, 64'd0, 64'h10, 1'b0, 16'h0000, 16'h0000, 1'b0);

    // Drain the scoreboard
    waited = 0;
    while (expQ.size() != 0 && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    if (expQ.size() != 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL drain: %0d responses outstanding, required 0", expQ.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL globalTimeout: simulation did not complete");
    $fatal(1, "[TB] timeout");
  end

endmodule
